image_pipe_src: RTL and testbench
=================================

Name: image_pipe_src

Overview:
Frame source (transmitter) for the image pipe streaming interface. It drives data/valid/end into an image pipe stage and honours the downstream busy back-pressure. It generates one frame of programmable length and pattern per start command. It is used as the upstream feeder for pipe stages in bring-up and in built-in self-test.

Parameters:
DW, 16, width of src_data_out (1..32)
LEN_W, 16, width of cfg_len (beats per frame)

Ports:
clk  input  1  clock
s_rst_n  input  1  synchronous active-low reset
start  input  1  single-cycle frame start request
abort  input  1  terminate current frame early
cfg_len  input  LEN_W  beats per frame; latched at start
cfg_mode  input  2  pattern: 0 incr, 1 constant, 2 checkerboard, 3 walking-one; latched at start
cfg_seed  input  DW  pattern seed; latched at start
src_data_out  output  DW  pixel data to downstream
src_valid_out  output  1  data qualifier
src_end_out  output  1  end-of-frame marker
src_busy_in  input  1  downstream busy (back-pressure)
src_active  output  1  high while a frame is in progress (state != IDLE)
src_done  output  1  one-cycle pulse when the frame completes
frame_cnt  output  16  completed-frame counter

Behaviour:
- Reset: s_rst_n is synchronous, active-low; clk is the clock. At the edge where s_rst_n=0, all outputs go to 0, state goes to IDLE, and latched config is cleared. A reset mid-frame drops valid/end immediately and does not pulse src_done.
- All outputs are registered.
- Transfer rule: a beat transfers at a clk edge where src_valid_out=1 and src_busy_in=0. While src_busy_in=1, src_data_out and src_valid_out hold their values unchanged.
- FSM states: IDLE, SEND, END.
- IDLE, start=1 at edge N:
  - Latch cfg_len/cfg_mode/cfg_seed and clear the beat index k.
  - If cfg_len!=0: go to SEND; from cycle N+1, src_valid_out=1 and src_data_out=pattern(0).
  - If cfg_len==0: go to END directly (end-only frame, no beats).
- start outside IDLE is ignored.
- SEND, on each transfer:
  - If k==len-1: valid<=0, end<=1, go to END.
  - Otherwise: k<=k+1 and data<=pattern(k+1); valid stays 1, giving back-to-back beats at one per cycle when not busy.
- SEND, abort=1 (checked before the transfer rule): valid<=0, end<=1, go to END. A beat transferring on that same edge counts as sent, but no further beats are issued.
- END:
  - src_end_out stays 1 until an edge with src_busy_in=0.
  - At that edge: end<=0, src_done<=1 for one cycle, frame_cnt<=frame_cnt+1 (wraps 0xFFFF->0), go to IDLE.
  - abort is ignored in END.
- src_end_out is never high in the same cycle as src_valid_out.
- Patterns, beat index k, DW-bit results, modulo 2^DW:
  - mode 0: seed+k
  - mode 1: seed
  - mode 2: seed for even k, ~seed for odd k
  - mode 3: 1<<(k mod DW)
- Beat index k is LEN_W bits and never wraps within a frame; maximum frame is 2^LEN_W-1 beats.
- start is accepted in the cycle after src_done (IDLE), so the minimum gap between frames is one IDLE cycle.
- Changes to cfg_* during a frame have no effect on that frame.

Test Plan:
- Basic: cfg_len=4, mode 0, seed=0x00F0, busy=0, start at cycle 10 -> valid in cycles 11-14 with data 0x00F0,0x00F1,0x00F2,0x00F3; end in cycle 15; src_done in cycle 16; frame_cnt=1.
- Back-pressure: cfg_len=3, mode 2, seed=0x5555, busy=1 in cycles 12-13 -> data 0x5555,0xAAAA,0x5555 each transferred exactly once; 0xAAAA held stable through cycles 12-14; end held while busy=1 in the END state.
- Walking-one wrap (DW=16): cfg_len=18, mode 3 -> beats 0..15 give 0x0001..0x8000; beats 16,17 give 0x0001,0x0002.
- Zero length and abort: cfg_len=0 -> no valid, one end cycle, then done. Separately, cfg_len=100 with abort after 5 transfers -> exactly 5 beats transferred, then end, then done; frame_cnt increments.
- Ignore/wrap: start pulsed during SEND -> no effect, and exactly cfg_len beats in the frame. Preload 0xFFFF completed frames, then one more -> frame_cnt=0x0000.
- Reset mid-frame: s_rst_n=0 while in SEND with busy=1 -> next cycle valid=0, end=0, src_active=0, no src_done; a new start after reset release produces a frame that begins at pattern(0).

Source files
------------

// File: rtl/image_pipe_src.sv
// -----------------------------------------------------------------------------
// image_pipe_src
//   Frame source for the image pipe streaming interface. Each start command
//   produces one frame of cfg_len beats using a selectable test pattern,
//   followed by a single end-of-frame marker cycle. Downstream back-pressure
//   (src_busy_in) stalls the stream with data/valid/end held stable.
//
// Ports
//   clk, s_rst_n      clock, synchronous active-low reset
//   start             one-cycle frame request (accepted only when idle)
//   abort             end the current frame early (only while sending)
//   cfg_len/mode/seed frame configuration, sampled when start is accepted
//   src_data_out      pixel data
//   src_valid_out     data qualifier
//   src_end_out       end-of-frame marker (never together with valid)
//   src_busy_in       downstream busy; no transfer while high
//   src_active        high while a frame is in progress
//   src_done          one-cycle pulse after the end marker is accepted
//   frame_cnt         completed-frame counter (wraps)
// -----------------------------------------------------------------------------
module image_pipe_src #(
  parameter int DW    = 16,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             s_rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [1:0]       cfg_mode,
  input  logic [DW-1:0]    cfg_seed,
  output logic [DW-1:0]    src_data_out,
  output logic             src_valid_out,
  output logic             src_end_out,
  input  logic             src_busy_in,
  output logic             src_active,
  output logic             src_done,
  output logic [15:0]      frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_END  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_INCR  = 2'd0;
  localparam logic [1:0] MODE_CONST = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;

  // Pattern value for beat k. The walking-one position uses a widened index
  // so the modulo divisor never truncates, whatever LEN_W is.
  function automatic logic [DW-1:0] pattern(input logic [1:0]       m,
                                            input logic [DW-1:0]    s,
                                            input logic [LEN_W-1:0] k);
    logic [LEN_W+5:0] kw;
    logic [LEN_W+5:0] sh;
    logic [DW-1:0]    r;
    kw = (LEN_W+6)'(k);
    sh = kw % (LEN_W+6)'(DW);
    case (m)
      MODE_INCR:  r = s + DW'(k);
      MODE_CONST: r = s;
      MODE_CHECK: r = k[0] ? ~s : s;
      default:    r = DW'(1) << sh;
    endcase
    return r;
  endfunction

  state_t           state_q,     state_d;
  logic [LEN_W-1:0] len_q,       len_d;
  logic [1:0]       mode_q,      mode_d;
  logic [DW-1:0]    seed_q,      seed_d;
  logic [LEN_W-1:0] k_q,         k_d;
  logic [DW-1:0]    data_q,      data_d;
  logic             valid_q,     valid_d;
  logic             end_q,       end_d;
  logic             active_q,    active_d;
  logic             done_q,      done_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic             xfer;
  logic             last_beat;
  logic [LEN_W-1:0] k_inc;

  assign xfer      = valid_q && !src_busy_in;
  assign k_inc     = k_q + LEN_W'(1);
  assign last_beat = (k_q == len_q - LEN_W'(1));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    mode_d      = mode_q;
    seed_d      = seed_q;
    k_d         = k_q;
    data_d      = data_q;
    valid_d     = valid_q;
    end_d       = end_q;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d  = cfg_len;
          mode_d = cfg_mode;
          seed_d = cfg_seed;
          k_d    = '0;
          if (cfg_len != '0) begin
            state_d = S_SEND;
            valid_d = 1'b1;
            data_d  = pattern(cfg_mode, cfg_seed, '0);
          end else begin
            // Empty frame: only the end marker is emitted.
            state_d = S_END;
            end_d   = 1'b1;
          end
        end
      end

      S_SEND: begin
        // Abort wins over the normal advance; a beat accepted on this same
        // edge is still counted as delivered by the consumer.
        if (abort) begin
          valid_d = 1'b0;
          end_d   = 1'b1;
          state_d = S_END;
        end else if (xfer) begin
          if (last_beat) begin
            valid_d = 1'b0;
            end_d   = 1'b1;
            state_d = S_END;
          end else begin
            k_d    = k_inc;
            data_d = pattern(mode_q, seed_q, k_inc);
          end
        end
      end

      S_END: begin
        // End marker is held until downstream can take it.
        if (!src_busy_in) begin
          end_d       = 1'b0;
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        end_d   = 1'b0;
      end
    endcase

    active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      mode_q      <= '0;
      seed_q      <= '0;
      k_q         <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      end_q       <= 1'b0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      seed_q      <= seed_d;
      k_q         <= k_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      end_q       <= end_d;
      active_q    <= active_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign src_data_out  = data_q;
  assign src_valid_out = valid_q;
  assign src_end_out   = end_q;
  assign src_active    = active_q;
  assign src_done      = done_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_image_pipe_src.sv
// -----------------------------------------------------------------------------
// tb_image_pipe_src
//   Directed bench for image_pipe_src (DW=16, LEN_W=16). Expected beats are
//   queued when a frame is started and compared as the source transfers them.
// -----------------------------------------------------------------------------
module tb_image_pipe_src;

  logic        clk;
  logic        s_rst_n;
  logic        start;
  logic        abort;
  logic [15:0] cfg_len;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_seed;
  logic [15:0] src_data_out;
  logic        src_valid_out;
  logic        src_end_out;
  logic        src_busy_in;
  logic        src_active;
  logic        src_done;
  logic [15:0] frame_cnt;

  image_pipe_src #(.DW(16), .LEN_W(16)) dut (
    .clk          (clk),
    .s_rst_n      (s_rst_n),
    .start        (start),
    .abort        (abort),
    .cfg_len      (cfg_len),
    .cfg_mode     (cfg_mode),
    .cfg_seed     (cfg_seed),
    .src_data_out (src_data_out),
    .src_valid_out(src_valid_out),
    .src_end_out  (src_end_out),
    .src_busy_in  (src_busy_in),
    .src_active   (src_active),
    .src_done     (src_done),
    .frame_cnt    (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks     = 0;
  int          failures   = 0;
  int          beats      = 0;
  int          end_cycles = 0;
  logic [15:0] fc_exp     = '0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [1:0] m, input logic [15:0] s, input int k);
    case (m)
      2'd0:    return s + 16'(k);
      2'd1:    return s;
      2'd2:    return (k % 2 == 1) ? ~s : s;
      default: return 16'h0001 << (k % 16);
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue nexp expected beats and pulse start with the given config.
  task automatic begin_frame(input int len, input int nexp, input logic [1:0] m, input logic [15:0] s);
    for (int k = 0; k < nexp; k++) exp_q.push_back(model(m, s, k));
    beats      = 0;
    end_cycles = 0;
    cfg_len    = 16'(len);
    cfg_mode   = m;
    cfg_seed   = s;
    start      = 1'b1;
    tick(1);
    start      = 1'b0;
  endtask

  // Wait (bounded) for src_done, then check frame accounting.
  task automatic finish_frame(input int nexp, input int bound);
    bit got;
    got = 0;
    for (int i = 0; i < bound; i++) begin
      tick(1);
      if (src_done) begin
        got = 1;
        break;
      end
    end
    chk("done_seen", {31'b0, got}, 32'd1);
    fc_exp = fc_exp + 16'd1;
    chk("frame_cnt", {16'b0, frame_cnt}, {16'b0, fc_exp});
    chk("beat_count", beats, nexp);
    chk("queue_drained", exp_q.size(), 0);
    tick(1);
    chk("done_one_cycle", {31'b0, src_done}, 32'd0);
  endtask

  // Transfer monitor: sample mid-cycle, compare each accepted beat.
  always @(negedge clk) begin
    if (s_rst_n) begin
      chk("valid_end_excl", {31'b0, src_valid_out & src_end_out}, 32'd0);
      if (src_end_out) end_cycles++;
      if (src_valid_out && !src_busy_in) begin
        beats++;
        if (exp_q.size() == 0) chk("extra_beat", 32'd1, 32'd0);
        else begin
          mon_exp = exp_q.pop_front();
          chk("beat_data", {16'b0, src_data_out}, {16'b0, mon_exp});
        end
      end
    end
  end

  initial begin
    s_rst_n     = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    cfg_len     = '0;
    cfg_mode    = '0;
    cfg_seed    = '0;
    src_busy_in = 1'b0;
    tick(3);
    chk("rst_valid",  {31'b0, src_valid_out}, 32'd0);
    chk("rst_end",    {31'b0, src_end_out},   32'd0);
    chk("rst_active", {31'b0, src_active},    32'd0);
    chk("rst_done",   {31'b0, src_done},      32'd0);
    chk("rst_data",   {16'b0, src_data_out},  32'd0);
    chk("rst_fcnt",   {16'b0, frame_cnt},     32'd0);
    s_rst_n = 1'b1;
    tick(6);

    // Basic: exact cycle timing of a 4-beat incrementing frame.
    begin_frame(4, 4, 2'd0, 16'h00F0);
    chk("basic_valid0", {31'b0, src_valid_out}, 32'd1);
    chk("basic_data0",  {16'b0, src_data_out},  32'h00F0);
    chk("basic_active", {31'b0, src_active},    32'd1);
    tick(3);
    chk("basic_valid3", {31'b0, src_valid_out}, 32'd1);
    chk("basic_data3",  {16'b0, src_data_out},  32'h00F3);
    tick(1);
    chk("basic_end",    {31'b0, src_end_out},   32'd1);
    chk("basic_novld",  {31'b0, src_valid_out}, 32'd0);
    tick(1);
    chk("basic_done",   {31'b0, src_done},      32'd1);
    chk("basic_end_lo", {31'b0, src_end_out},   32'd0);
    chk("basic_fcnt",   {16'b0, frame_cnt},     32'd1);
    chk("basic_beats",  beats, 4);
    fc_exp = 16'd1;
    tick(1);
    chk("basic_done_lo", {31'b0, src_done},   32'd0);
    chk("basic_idle",    {31'b0, src_active}, 32'd0);
    tick(2);

    // Back-pressure on a checkerboard frame, including during END.
    begin_frame(3, 3, 2'd2, 16'h5555);
    tick(1);                       // beat 0 accepted
    src_busy_in = 1'b1;
    tick(1);
    chk("bp_hold_a", {16'b0, src_data_out}, 32'hAAAA);
    chk("bp_vld_a",  {31'b0, src_valid_out}, 32'd1);
    tick(1);
    chk("bp_hold_b", {16'b0, src_data_out}, 32'hAAAA);
    src_busy_in = 1'b0;
    tick(2);                       // beats 1 and 2 accepted
    chk("bp_end", {31'b0, src_end_out}, 32'd1);
    src_busy_in = 1'b1;
    tick(2);
    chk("bp_end_held", {31'b0, src_end_out}, 32'd1);
    chk("bp_no_done",  {31'b0, src_done},    32'd0);
    src_busy_in = 1'b0;
    finish_frame(3, 5);
    tick(1);

    // Walking one wraps after 16 beats.
    begin_frame(18, 18, 2'd3, 16'h0000);
    finish_frame(18, 30);

    // Constant pattern.
    begin_frame(5, 5, 2'd1, 16'hC3A5);
    finish_frame(5, 15);

    // Zero length: just the end marker.
    begin_frame(0, 0, 2'd0, 16'h1234);
    chk("zl_end",   {31'b0, src_end_out},   32'd1);
    chk("zl_novld", {31'b0, src_valid_out}, 32'd0);
    finish_frame(0, 5);
    chk("zl_end_cycles", end_cycles, 1);

    // Abort raised on the edge of the 5th transfer.
    begin_frame(100, 5, 2'd0, 16'h0100);
    tick(4);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("ab_end", {31'b0, src_end_out}, 32'd1);
    finish_frame(5, 10);

    // start and config changes mid-frame have no effect.
    begin_frame(6, 6, 2'd0, 16'h7FFE);
    tick(2);
    cfg_len  = 16'd2;
    cfg_mode = 2'd1;
    cfg_seed = 16'hFFFF;
    start    = 1'b1;
    tick(1);
    start    = 1'b0;
    finish_frame(6, 15);

    // Counter wrap: preload 0xFFFF completed frames, then one more.
    force dut.frame_cnt_d = 16'hFFFF;
    tick(1);
    release dut.frame_cnt_d;
    fc_exp = 16'hFFFF;
    chk("wrap_preload", {16'b0, frame_cnt}, 32'h0000FFFF);
    begin_frame(1, 1, 2'd2, 16'h0F0F);
    finish_frame(1, 5);
    chk("wrap_zero", {16'b0, frame_cnt}, 32'd0);

    // Reset while stalled in SEND.
    begin_frame(10, 10, 2'd0, 16'h2000);
    tick(2);
    src_busy_in = 1'b1;
    s_rst_n     = 1'b0;
    tick(1);
    chk("mr_valid",  {31'b0, src_valid_out}, 32'd0);
    chk("mr_end",    {31'b0, src_end_out},   32'd0);
    chk("mr_active", {31'b0, src_active},    32'd0);
    chk("mr_done",   {31'b0, src_done},      32'd0);
    chk("mr_fcnt",   {16'b0, frame_cnt},     32'd0);
    s_rst_n     = 1'b1;
    src_busy_in = 1'b0;
    exp_q.delete();
    fc_exp = '0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("mr_no_done", {31'b0, src_done}, 32'd0);
    end
    begin_frame(3, 3, 2'd0, 16'h2000);
    chk("mr_restart_data", {16'b0, src_data_out}, 32'h2000);
    finish_frame(3, 8);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
